// File: rtl/router_pkt_loader.sv
// router_pkt_loader: input-side writer of the 1x3 router.
// Decodes the packet header, steers header and payload bytes into one of
// three output FIFOs, checks the trailing parity byte and keeps saturating
// debug counters. The write path (wr_en, dout, lfd_state) and busy are
// combinational so the FIFO captures the byte on the same edge it is accepted.
// i_rst is active low and asynchronous.

module router_pkt_loader #(
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_pkt_valid,
   input  logic [7:0]       i_din,
   input  logic [2:0]       i_fifo_full,
   output logic             o_busy,
   output logic [2:0]       o_wr_en,
   output logic             o_lfd_state,
   output logic [7:0]       o_dout,
   output logic             o_err,
   output logic             o_pkt_done,
   output logic [CNT_W-1:0] o_pkt_cnt,
   output logic [CNT_W-1:0] o_err_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_PARITY = 2'd2,
      ST_DROP   = 2'd3
   } state_t;

   // Running parity: XOR fold of one more byte into the accumulator.
   function automatic logic [7:0] f_par_fold(input logic [7:0] acc, input logic [7:0] b);
      return acc ^ b;
   endfunction

   // Saturating increment: counters stick at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] c);
      if (&c) begin
         return c;
      end else begin
         return c + CNT_W'(1);
      end
   endfunction

   state_t           r_state;
   state_t           w_state_nxt;
   logic [5:0]       r_rem;
   logic [5:0]       w_rem_nxt;
   logic [1:0]       r_addr;
   logic [1:0]       w_addr_nxt;
   logic [7:0]       r_par;
   logic [7:0]       w_par_nxt;
   logic             r_err;
   logic             r_done;
   logic             w_err_nxt;
   logic             w_done_nxt;
   logic             w_good;
   logic [CNT_W-1:0] r_pkt_cnt;
   logic [CNT_W-1:0] r_err_cnt;

   logic [1:0]       w_tgt;
   logic             w_tgt_full;
   logic             w_busy;
   logic             w_accept;
   logic [2:0]       w_wr_en;
   logic             w_lfd;
   logic             w_hdr_bad;

   // Target FIFO: the header's address while idle, the latched one afterwards.
   always_comb begin
      w_tgt = r_addr;
      if (r_state == ST_IDLE) begin
         w_tgt = i_din[1:0];
      end else begin
         w_tgt = r_addr;
      end
   end

   // Full flag of the target FIFO only; address 3 has no FIFO behind it.
   always_comb begin
      w_tgt_full = 1'b0;
      case (w_tgt)
         2'd0:    w_tgt_full = i_fifo_full[0];
         2'd1:    w_tgt_full = i_fifo_full[1];
         2'd2:    w_tgt_full = i_fifo_full[2];
         default: w_tgt_full = 1'b0;
      endcase
   end

   assign w_hdr_bad = (i_din[1:0] == 2'd3);

   // Backpressure: only while a write to a full FIFO is pending; never during reset.
   always_comb begin
      w_busy = 1'b0;
      if (!i_rst) begin
         w_busy = 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: w_busy = w_hdr_bad ? 1'b0 : w_tgt_full;
            ST_LOAD: w_busy = w_tgt_full;
            default: w_busy = 1'b0;
         endcase
      end
   end

   assign w_accept = i_rst & i_pkt_valid & ~w_busy;

   // Write path: header (valid address) and payload bytes go to the target FIFO.
   always_comb begin
      w_wr_en = 3'b000;
      w_lfd   = 1'b0;
      if (w_accept) begin
         case (r_state)
            ST_IDLE: begin
               w_lfd = 1'b1;
               case (w_tgt)
                  2'd0:    w_wr_en = 3'b001;
                  2'd1:    w_wr_en = 3'b010;
                  2'd2:    w_wr_en = 3'b100;
                  default: w_wr_en = 3'b000;
               endcase
            end
            ST_LOAD: begin
               case (w_tgt)
                  2'd0:    w_wr_en = 3'b001;
                  2'd1:    w_wr_en = 3'b010;
                  2'd2:    w_wr_en = 3'b100;
                  default: w_wr_en = 3'b000;
               endcase
            end
            default: w_wr_en = 3'b000;
         endcase
      end else begin
         w_wr_en = 3'b000;
         w_lfd   = 1'b0;
      end
   end

   // Packet FSM: next state, remaining-byte count, address and parity updates.
   always_comb begin
      w_state_nxt = r_state;
      w_rem_nxt   = r_rem;
      w_addr_nxt  = r_addr;
      w_par_nxt   = r_par;
      w_err_nxt   = 1'b0;
      w_done_nxt  = 1'b0;
      w_good      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_addr_nxt = i_din[1:0];
               w_rem_nxt  = i_din[7:2];
               w_par_nxt  = i_din;
               if (w_hdr_bad) begin
                  w_state_nxt = ST_DROP;
               end else if (i_din[7:2] != 6'd0) begin
                  w_state_nxt = ST_LOAD;
               end else begin
                  w_state_nxt = ST_PARITY;
               end
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (w_accept) begin
               w_par_nxt = f_par_fold(r_par, i_din);
               w_rem_nxt = r_rem - 6'd1;
               if (r_rem == 6'd1) begin
                  w_state_nxt = ST_PARITY;
               end else begin
                  w_state_nxt = ST_LOAD;
               end
            end else begin
               w_state_nxt = ST_LOAD;
            end
         end
         ST_PARITY: begin
            if (w_accept) begin
               w_done_nxt  = 1'b1;
               w_state_nxt = ST_IDLE;
               if (i_din != r_par) begin
                  w_err_nxt = 1'b1;
               end else begin
                  w_good = 1'b1;
               end
            end else begin
               w_state_nxt = ST_PARITY;
            end
         end
         ST_DROP: begin
            // rem counts the payload still to discard; rem==0 means parity byte.
            if (w_accept) begin
               if (r_rem == 6'd0) begin
                  w_err_nxt   = 1'b1;
                  w_done_nxt  = 1'b1;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_rem_nxt   = r_rem - 6'd1;
                  w_state_nxt = ST_DROP;
               end
            end else begin
               w_state_nxt = ST_DROP;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // FSM and packet-context registers.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_state <= ST_IDLE;
         r_rem   <= 6'd0;
         r_addr  <= 2'd0;
         r_par   <= 8'd0;
      end else begin
         r_state <= w_state_nxt;
         r_rem   <= w_rem_nxt;
         r_addr  <= w_addr_nxt;
         r_par   <= w_par_nxt;
      end
   end

   // End-of-packet pulses, asserted the cycle after the parity byte.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_err  <= 1'b0;
         r_done <= 1'b0;
      end else begin
         r_err  <= w_err_nxt;
         r_done <= w_done_nxt;
      end
   end

   // Saturating statistics: good packets and flagged packets.
   always_ff @(posedge i_clk or negedge i_rst) begin
      if (!i_rst) begin
         r_pkt_cnt <= '0;
         r_err_cnt <= '0;
      end else begin
         if (w_good) begin
            r_pkt_cnt <= f_sat_inc(r_pkt_cnt);
         end else begin
            r_pkt_cnt <= r_pkt_cnt;
         end
         if (w_err_nxt) begin
            r_err_cnt <= f_sat_inc(r_err_cnt);
         end else begin
            r_err_cnt <= r_err_cnt;
         end
      end
   end

   assign o_busy      = w_busy;
   assign o_wr_en     = w_wr_en;
   assign o_lfd_state = w_lfd;
   assign o_dout      = i_din;
   assign o_err       = r_err;
   assign o_pkt_done  = r_done;
   assign o_pkt_cnt   = r_pkt_cnt;
   assign o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_router_pkt_loader.sv
// Directed testbench for router_pkt_loader. Counters are built 2 bits wide
// so that saturation at all-ones is reached within the directed sequence.

module tb_router_pkt_loader;

   localparam int CW = 2;

   logic          i_clk;
   logic          i_rst;
   logic          i_pkt_valid;
   logic [7:0]    i_din;
   logic [2:0]    i_fifo_full;
   logic          o_busy;
   logic [2:0]    o_wr_en;
   logic          o_lfd_state;
   logic [7:0]    o_dout;
   logic          o_err;
   logic          o_pkt_done;
   logic [CW-1:0] o_pkt_cnt;
   logic [CW-1:0] o_err_cnt;

   int n_tests;
   int n_fail;

   router_pkt_loader #(.CNT_W(CW)) dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_pkt_valid (i_pkt_valid),
      .i_din       (i_din),
      .i_fifo_full (i_fifo_full),
      .o_busy      (o_busy),
      .o_wr_en     (o_wr_en),
      .o_lfd_state (o_lfd_state),
      .o_dout      (o_dout),
      .o_err       (o_err),
      .o_pkt_done  (o_pkt_done),
      .o_pkt_cnt   (o_pkt_cnt),
      .o_err_cnt   (o_err_cnt)
   );

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Entered at posedge+1: drive a byte, check the combinational write side
   // mid-cycle, then advance to just after the next rising edge.
   task automatic byte_chk(input string tag, input logic v, input logic [7:0] d,
                           input logic [2:0] ew, input logic el, input logic eb);
      i_pkt_valid = v;
      i_din       = d;
      #2;
      chk({tag, "_wr"},   {29'd0, o_wr_en}, {29'd0, ew});
      chk({tag, "_lfd"},  {31'd0, o_lfd_state}, {31'd0, el});
      chk({tag, "_busy"}, {31'd0, o_busy}, {31'd0, eb});
      chk({tag, "_dout"}, {24'd0, o_dout}, {24'd0, d});
      @(posedge i_clk);
      #1;
   endtask

   task automatic end_chk(input string tag, input logic ee, input logic ed,
                          input logic [CW-1:0] epc, input logic [CW-1:0] eec);
      chk({tag, "_err"},  {31'd0, o_err}, {31'd0, ee});
      chk({tag, "_done"}, {31'd0, o_pkt_done}, {31'd0, ed});
      chk({tag, "_pcnt"}, {30'd0, o_pkt_cnt}, {30'd0, epc});
      chk({tag, "_ecnt"}, {30'd0, o_err_cnt}, {30'd0, eec});
   endtask

   initial begin
      n_tests     = 0;
      n_fail      = 0;
      i_rst       = 1'b0;
      i_pkt_valid = 1'b1;
      i_din       = 8'h0D;
      i_fifo_full = 3'b010;

      // Reset state: outputs quiet even with a valid header and a full target.
      #2;
      chk("rst_wr",   {29'd0, o_wr_en}, 32'd0);
      chk("rst_busy", {31'd0, o_busy}, 32'd0);
      chk("rst_lfd",  {31'd0, o_lfd_state}, 32'd0);
      chk("rst_dout", {24'd0, o_dout}, 32'h0D);
      end_chk("rst", 1'b0, 1'b0, 2'd0, 2'd0);
      @(posedge i_clk);
      #1;
      i_rst       = 1'b1;
      i_pkt_valid = 1'b0;
      i_fifo_full = 3'b000;
      byte_chk("idle0", 1'b0, 8'h03, 3'b000, 1'b0, 1'b0);

      // Good packet to FIFO1: 0D ^ A1 ^ B2 ^ C3 = DD.
      byte_chk("p1_hdr", 1'b1, 8'h0D, 3'b010, 1'b1, 1'b0);
      byte_chk("p1_b0",  1'b1, 8'hA1, 3'b010, 1'b0, 1'b0);
      byte_chk("p1_b1",  1'b1, 8'hB2, 3'b010, 1'b0, 1'b0);
      byte_chk("p1_b2",  1'b1, 8'hC3, 3'b010, 1'b0, 1'b0);
      byte_chk("p1_par", 1'b1, 8'hDD, 3'b000, 1'b0, 1'b0);
      end_chk("p1", 1'b0, 1'b1, 2'd1, 2'd0);
      byte_chk("p1_gap", 1'b0, 8'h03, 3'b000, 1'b0, 1'b0);
      end_chk("p1_after", 1'b0, 1'b0, 2'd1, 2'd0);

      // Same packet, wrong parity; includes a valid gap mid-payload.
      byte_chk("p2_hdr", 1'b1, 8'h0D, 3'b010, 1'b1, 1'b0);
      byte_chk("p2_b0",  1'b1, 8'hA1, 3'b010, 1'b0, 1'b0);
      byte_chk("p2_gap", 1'b0, 8'hB2, 3'b000, 1'b0, 1'b0);
      byte_chk("p2_b1",  1'b1, 8'hB2, 3'b010, 1'b0, 1'b0);
      byte_chk("p2_b2",  1'b1, 8'hC3, 3'b010, 1'b0, 1'b0);
      byte_chk("p2_par", 1'b1, 8'h00, 3'b000, 1'b0, 1'b0);
      end_chk("p2", 1'b1, 1'b1, 2'd1, 2'd1);
      byte_chk("p2_idle", 1'b0, 8'h03, 3'b000, 1'b0, 1'b0);
      end_chk("p2_after", 1'b0, 1'b0, 2'd1, 2'd1);

      // FIFO0 stall: 08 ^ 11 ^ 22 = 3B; second payload held 3 cycles.
      byte_chk("p3_hdr", 1'b1, 8'h08, 3'b001, 1'b1, 1'b0);
      byte_chk("p3_b0",  1'b1, 8'h11, 3'b001, 1'b0, 1'b0);
      i_fifo_full = 3'b001;
      for (int k = 0; k < 3; k++) begin
         byte_chk("p3_stall", 1'b1, 8'h22, 3'b000, 1'b0, 1'b1);
      end
      i_fifo_full = 3'b000;
      byte_chk("p3_b1",  1'b1, 8'h22, 3'b001, 1'b0, 1'b0);
      byte_chk("p3_par", 1'b1, 8'h3B, 3'b000, 1'b0, 1'b0);
      end_chk("p3", 1'b0, 1'b1, 2'd2, 2'd1);

      // Address 3: dropped, never busy even with every FIFO full.
      i_fifo_full = 3'b111;
      byte_chk("p4_hdr", 1'b1, 8'h07, 3'b000, 1'b1, 1'b0);
      byte_chk("p4_b0",  1'b1, 8'h55, 3'b000, 1'b0, 1'b0);
      byte_chk("p4_par", 1'b1, 8'h00, 3'b000, 1'b0, 1'b0);
      end_chk("p4", 1'b1, 1'b1, 2'd2, 2'd2);
      byte_chk("p4_idle", 1'b0, 8'h03, 3'b000, 1'b0, 1'b0);

      // L=0 to FIFO2, then back-to-back header to FIFO1 with FIFO0 full.
      i_fifo_full = 3'b001;
      byte_chk("p5_hdr", 1'b1, 8'h02, 3'b100, 1'b1, 1'b0);
      byte_chk("p5_par", 1'b1, 8'h02, 3'b000, 1'b0, 1'b0);
      end_chk("p5", 1'b0, 1'b1, 2'd3, 2'd2);
      byte_chk("p6_hdr", 1'b1, 8'h05, 3'b010, 1'b1, 1'b0);
      end_chk("p6_mid", 1'b0, 1'b0, 2'd3, 2'd2);
      byte_chk("p6_b0",  1'b1, 8'h77, 3'b010, 1'b0, 1'b0);
      byte_chk("p6_par", 1'b1, 8'h72, 3'b000, 1'b0, 1'b0);
      end_chk("p6_sat", 1'b0, 1'b1, 2'd3, 2'd2);

      // Reset during second payload byte of an L=5 packet to FIFO0.
      i_fifo_full = 3'b000;
      byte_chk("p7_hdr", 1'b1, 8'h14, 3'b001, 1'b1, 1'b0);
      byte_chk("p7_b0",  1'b1, 8'h01, 3'b001, 1'b0, 1'b0);
      i_fifo_full = 3'b001;
      i_rst       = 1'b0;
      byte_chk("p7_rst", 1'b1, 8'h02, 3'b000, 1'b0, 1'b0);
      end_chk("p7_rst", 1'b0, 1'b0, 2'd0, 2'd0);
      i_rst       = 1'b1;
      i_fifo_full = 3'b000;

      // Fresh packet after reset: starts from IDLE and completes normally.
      byte_chk("p8_hdr", 1'b1, 8'h0D, 3'b010, 1'b1, 1'b0);
      byte_chk("p8_b0",  1'b1, 8'hA1, 3'b010, 1'b0, 1'b0);
      byte_chk("p8_b1",  1'b1, 8'hB2, 3'b010, 1'b0, 1'b0);
      byte_chk("p8_b2",  1'b1, 8'hC3, 3'b010, 1'b0, 1'b0);
      byte_chk("p8_par", 1'b1, 8'hDD, 3'b000, 1'b0, 1'b0);
      end_chk("p8", 1'b0, 1'b1, 2'd1, 2'd0);
      byte_chk("p8_idle", 1'b0, 8'h03, 3'b000, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/router_pkt_loader.md
Name: router_pkt_loader

Overview:
- Input-side packet loader for the 1x3 router. It is the writer that feeds the three 16-deep, 9-bit output FIFOs.
- Accepts a byte stream from the packet source, decodes the header and steers header and payload bytes into the selected FIFO. It tags the header byte with lfd_state.
- Applies backpressure (busy) while the target FIFO is full. The trailing parity byte is checked, not stored.
- Keeps saturating packet and error counters for debug.

Parameters:
- CNT_W, 8, width of the pkt_cnt and err_cnt statistics counters.

Ports:
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  asynchronous, active-low reset
- pkt_valid  input  1  source presents a valid byte on din
- din  input  8  packet byte from source
- fifo_full  input  3  full flags of FIFO0..FIFO2
- busy  output  1  stall: source must hold din/pkt_valid while high
- wr_en  output  3  one-hot write enable to FIFO0..FIFO2
- lfd_state  output  1  marks the header byte on the FIFO write bus
- dout  output  8  write data to the FIFOs
- err  output  1  one-cycle pulse: parity mismatch or invalid address
- pkt_done  output  1  one-cycle pulse after any packet's parity byte is consumed
- pkt_cnt  output  CNT_W  packets completed with good parity, saturating
- err_cnt  output  CNT_W  packets flagged by err, saturating

Behaviour:
- Packet format:
  - Header: din[7:2] = payload length L (0..63); din[1:0] = destination address (0..2; 3 is invalid).
  - Then L payload bytes, then one parity byte equal to the XOR of the header and all payload bytes.
- Handshake:
  - A byte is accepted on a rising edge where pkt_valid=1 and busy=0. One byte per cycle at most.
  - pkt_valid may drop between bytes; state and counters hold through gaps.
- Target address tgt:
  - In IDLE, tgt = din[1:0].
  - Otherwise tgt = the latched addr_q.
- busy (combinational):
  - In IDLE and LOAD: busy = fifo_full[tgt].
  - Forced 0 for address 3 in IDLE.
  - Always 0 in PARITY and DROP.
- Write path is zero-latency combinational:
  - wr_en[tgt] = accept && state in {IDLE with valid address, LOAD}.
  - dout = din.
  - lfd_state = accept in IDLE.
  - The FIFO registers the write on the same edge.
- States:
  - IDLE: on accept, latch addr_q and rem = din[7:2], and set parity_acc = din.
    - Address 3: go to DROP, no write.
    - Otherwise write the header, then go to LOAD if L != 0, else to PARITY.
  - LOAD: on accept, write the byte, parity_acc ^= din, rem decrements. When rem reaches 1 on accept, go to PARITY.
  - PARITY: on accept, do not write; compare din with parity_acc and go to IDLE.
    - Mismatch: err pulses next cycle, err_cnt increments.
    - Match: pkt_cnt increments.
    - pkt_done pulses next cycle in both cases.
  - DROP: consume rem payload bytes plus the parity byte with no writes. After the parity byte, pulse err and pkt_done, increment err_cnt, go to IDLE.
- Registered outputs and counters:
  - err and pkt_done are registered, so they assert in the cycle after the parity byte is accepted.
  - Counters saturate at all-ones and never wrap.
- Back-to-back packets: a header may be accepted in the first cycle after PARITY/DROP exits, i.e. the cycle err/pkt_done pulse.
- fifo_full on a non-target FIFO never affects busy.
- Reset (async, any time):
  - State returns to IDLE; rem, addr_q, parity_acc, pkt_cnt and err_cnt clear.
  - err and pkt_done are 0; wr_en, lfd_state and busy are 0 while rst=0; dout = din.
  - A packet interrupted mid-stream is abandoned; no recovery of the partial FIFO contents.

Test Plan:
- Header 8'h0D (L=3, addr 1), payload 8'hA1, 8'hB2, 8'hC3, parity 8'hDD, fifo_full=0 → wr_en=3'b010 for 4 cycles; lfd_state=1 only on 8'h0D; parity byte not written; pkt_done pulse, err=0, pkt_cnt=1.
- Same packet but parity 8'h00 → 4 writes to FIFO1, err and pkt_done pulse one cycle after the parity byte, err_cnt=1, pkt_cnt unchanged.
- Header 8'h08 (L=2, addr 0) with fifo_full[0]=1 for 3 cycles after the first payload byte → busy=1 and wr_en=0 during the stall; the second payload byte is accepted on the first edge after fifo_full[0] falls; no byte lost or duplicated.
- Header 8'h07 (L=1, addr 3), one payload byte, parity byte → no wr_en at any point, busy=0 throughout, err pulse, err_cnt=1.
- Header 8'h02 (L=0, addr 2), parity 8'h02, then header 8'h05 (L=1, addr 1) on the next cycle → FIFO2 receives only the header; the back-to-back header is accepted immediately; fifo_full[0]=1 during this has no effect on busy.
- Assert rst low during the second payload byte of an L=5 packet → wr_en/busy=0 immediately; after release, state is IDLE and a new 8'h0D packet completes normally with pkt_cnt=1.
